// File: rtl/ps2_pkg.sv
// Shared scancode constants, prefix-state type and digit decoder for the PS/2 digit stream.
// Macro PS2_KEYPAD_EN adds numeric-keypad scancodes to the digit table.
package ps2_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   localparam logic [7:0] SC_D0 = 8'h45;
   localparam logic [7:0] SC_D1 = 8'h16;
   localparam logic [7:0] SC_D2 = 8'h1E;
   localparam logic [7:0] SC_D3 = 8'h26;
   localparam logic [7:0] SC_D4 = 8'h25;
   localparam logic [7:0] SC_D5 = 8'h2E;
   localparam logic [7:0] SC_D6 = 8'h36;
   localparam logic [7:0] SC_D7 = 8'h3D;
   localparam logic [7:0] SC_D8 = 8'h3E;
   localparam logic [7:0] SC_D9 = 8'h46;

   localparam logic [7:0] SC_KP0 = 8'h70;
   localparam logic [7:0] SC_KP1 = 8'h69;
   localparam logic [7:0] SC_KP2 = 8'h72;
   localparam logic [7:0] SC_KP3 = 8'h7A;
   localparam logic [7:0] SC_KP4 = 8'h6B;
   localparam logic [7:0] SC_KP5 = 8'h73;
   localparam logic [7:0] SC_KP6 = 8'h74;
   localparam logic [7:0] SC_KP7 = 8'h6C;
   localparam logic [7:0] SC_KP8 = 8'h75;
   localparam logic [7:0] SC_KP9 = 8'h7D;

   typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} prefix_state_e;

   // Returns {hit, digit}; digit is 0 when hit is clear.
   function automatic logic [4:0] sc_to_digit(input logic [7:0] code);
      logic [4:0] r;
      r = 5'd0;
      case (code)
         SC_D0:   r = {1'b1, 4'd0};
         SC_D1:   r = {1'b1, 4'd1};
         SC_D2:   r = {1'b1, 4'd2};
         SC_D3:   r = {1'b1, 4'd3};
         SC_D4:   r = {1'b1, 4'd4};
         SC_D5:   r = {1'b1, 4'd5};
         SC_D6:   r = {1'b1, 4'd6};
         SC_D7:   r = {1'b1, 4'd7};
         SC_D8:   r = {1'b1, 4'd8};
         SC_D9:   r = {1'b1, 4'd9};
`ifdef PS2_KEYPAD_EN
         SC_KP0:  r = {1'b1, 4'd0};
         SC_KP1:  r = {1'b1, 4'd1};
         SC_KP2:  r = {1'b1, 4'd2};
         SC_KP3:  r = {1'b1, 4'd3};
         SC_KP4:  r = {1'b1, 4'd4};
         SC_KP5:  r = {1'b1, 4'd5};
         SC_KP6:  r = {1'b1, 4'd6};
         SC_KP7:  r = {1'b1, 4'd7};
         SC_KP8:  r = {1'b1, 4'd8};
         SC_KP9:  r = {1'b1, 4'd9};
`endif
         default: r = 5'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_digit_fifo.sv
// Small power-of-two FIFO for decoded digits; a pop in the same cycle frees room for a push.
module ps2_digit_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign data_o  = empty_o ? '0 : mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/ps2_digit_stream.sv
// PS/2 set-2 byte stream to buffered digit stream: prefix tracking, repeat filter, overflow flag.
// Macro PS2_KEYPAD_EN (via ps2_pkg) also accepts numeric-keypad digit codes.
module ps2_digit_stream
   import ps2_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int REPEAT_FILTER = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] code,
   input  logic       code_valid,
   output logic [3:0] out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       bad_code,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int CW = $clog2(DEPTH + 1);

   prefix_state_e state_q, state_d;
   logic          held_vld_q, held_vld_d;
   logic [7:0]    held_code_q, held_code_d;
   logic          bad_q, bad_d;
   logic          ovf_q, ovf_d;
   logic [4:0]    dec;
   logic          is_repeat, push, pop, fifo_full, fifo_empty;
   logic [CW-1:0] unused_count;

   assign dec       = sc_to_digit(code);
   assign is_repeat = (REPEAT_FILTER != 0) && held_vld_q && (code == held_code_q);
   assign pop       = out_ready && !fifo_empty;

   always_comb begin
      state_d     = state_q;
      held_vld_d  = held_vld_q;
      held_code_d = held_code_q;
      bad_d       = 1'b0;
      push        = 1'b0;
      if (code_valid) begin
         if (code == SC_EXT) begin
            state_d = EXT;
         end else if (code == SC_BREAK) begin
            if (state_q == IDLE)     state_d = BREAK;
            else if (state_q == EXT) state_d = EXT_BREAK;
         end else begin
            state_d = IDLE;
            case (state_q)
               IDLE: begin
                  if (dec[4]) begin
                     held_vld_d  = 1'b1;
                     held_code_d = code;
                     push        = !is_repeat;
                  end else begin
                     bad_d = 1'b1;
                  end
               end
               BREAK: if (code == held_code_q) held_vld_d = 1'b0;
               // Extended keys never produce digits and never touch held state.
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         held_vld_q  <= 1'b0;
         held_code_q <= 8'h00;
         bad_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_vld_q  <= held_vld_d;
         held_code_q <= held_code_d;
         bad_q       <= bad_d;
         ovf_q       <= ovf_d;
      end
   end

   ps2_digit_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (dec[3:0]),
      .pop_i   (pop),
      .data_o  (out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_count)
   );

   assign out_valid = !fifo_empty;
   assign bad_code  = bad_q;
   assign overflow  = ovf_q;

endmodule
